// File: rtl/countdown_limiter.sv
// countdown_limiter: bounded down-counter that drains a loaded count one tick
// per enabled cycle. It pulses done when the count reaches zero and pulses
// load_err when a load above MAX_LOAD is rejected, so counter never exceeds
// MAX_LOAD.
module countdown_limiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_LOAD = 100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] counter,
  output logic             busy,
  output logic             done,
  output logic             load_err
);

  // An unusable limit is caught at elaboration: it must be non-zero and fit in WIDTH bits.
  if (MAX_LOAD <= 0 || longint'(MAX_LOAD) >= (longint'(1) << WIDTH)) begin : g_bad_max_load
    $error("countdown_limiter: MAX_LOAD must satisfy 0 < MAX_LOAD < 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxLoadW = WIDTH'(MAX_LOAD);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] counter_q;
  logic [WIDTH-1:0] counter_dec_d;
  logic             busy_q;
  logic             done_q;
  logic             load_err_q;

  // Decremented count, used only while RUN, where the counter is always at least 1.
  always_comb begin
    counter_dec_d = counter_q - {{(WIDTH-1){1'b0}}, 1'b1};
  end

  // Control FSM. Priority on each edge is clear, then load, then decrement.
  // done and load_err default low, so each one lasts a single cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      if (clear) begin
        // An abort drops any simultaneous load silently and gives no completion.
        state_q   <= IDLE;
        counter_q <= '0;
        busy_q    <= 1'b0;
      end else if (load) begin
        if (load_value > MaxLoadW) begin
          // A rejected load leaves the count that is already running untouched.
          load_err_q <= 1'b1;
        end else if (load_value == '0) begin
          // A zero-length count completes at once.
          state_q   <= IDLE;
          counter_q <= '0;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
        end else begin
          // A load (re)starts the count. There is no decrement on the load edge.
          state_q   <= RUN;
          counter_q <= load_value;
          busy_q    <= 1'b1;
        end
      end else if (state_q == RUN && enable) begin
        if (counter_q > {{(WIDTH-1){1'b0}}, 1'b1}) begin
          counter_q <= counter_dec_d;
        end else begin
          state_q   <= IDLE;
          counter_q <= '0;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
        end
      end
    end
  end

  assign counter  = counter_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign load_err = load_err_q;

  // The counter never exceeds the load limit.
  a_counter_le_max : assert property (@(posedge clk) disable iff (!reset_n)
    counter_q <= MaxLoadW);

  // Once at zero, the counter stays at zero until a new load arrives (no wrap below zero).
  a_no_wrap : assert property (@(posedge clk) disable iff (!reset_n)
    (counter_q == '0 && !load) |=> counter_q == '0);

  // A running count always has at least one tick left.
  a_busy_nonzero : assert property (@(posedge clk) disable iff (!reset_n)
    busy_q |-> counter_q != '0);

  // Completion is only reported with an empty, idle counter.
  a_done_idle_zero : assert property (@(posedge clk) disable iff (!reset_n)
    done_q |-> (counter_q == '0 && !busy_q));

  // A completion and a rejection never coincide.
  a_done_err_exclusive : assert property (@(posedge clk) disable iff (!reset_n)
    !(done_q && load_err_q));

endmodule

// File: tb/tb_countdown_limiter.sv
// Scoreboarded bench for countdown_limiter. The driver steps a remaining-ticks
// model on every edge and queues the expected outputs. A monitor pops one
// expectation after each rising edge and compares it with the DUT outputs.
module tb_countdown_limiter;

  localparam int WIDTH    = 8;
  localparam int MAX_LOAD = 100;

  logic             clk;
  logic             reset_n;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic [WIDTH-1:0] counter;
  logic             busy;
  logic             done;
  logic             load_err;

  countdown_limiter #(.WIDTH(WIDTH), .MAX_LOAD(MAX_LOAD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .load      (load),
    .load_value(load_value),
    .enable    (enable),
    .counter   (counter),
    .busy      (busy),
    .done      (done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit busy;
    bit done;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // The model keeps only the number of ticks left. "Busy" means ticks remain.
  int   m_left = 0;
  bit   m_done = 0;
  bit   m_err  = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_step(input bit clr, input bit ld, input int lv, input bit en);
    m_done = 0;
    m_err  = 0;
    if (clr) begin
      m_left = 0;
    end else if (ld) begin
      if (lv > MAX_LOAD) m_err = 1;
      else begin
        m_left = lv;
        if (lv == 0) m_done = 1;
      end
    end else if (m_left > 0 && en) begin
      m_left = m_left - 1;
      if (m_left == 0) m_done = 1;
    end
  endfunction

  function automatic void push_expect();
    exp_t e;
    e.cnt  = m_left;
    e.busy = (m_left > 0);
    e.done = m_done;
    e.err  = m_err;
    exp_q.push_back(e);
  endfunction

  // Drives the inputs for the coming edge (the caller is already at a falling edge).
  task automatic drive(input bit clr, input bit ld, input int lv, input bit en);
    clear      = clr;
    load       = ld;
    load_value = lv[WIDTH-1:0];
    enable     = en;
    model_step(clr, ld, lv, en);
    push_expect();
  endtask

  task automatic cycle(input bit clr, input bit ld, input int lv, input bit en);
    @(negedge clk);
    drive(clr, ld, lv, en);
  endtask

  // Monitor: after every rising edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("counter",  int'(counter),  e.cnt);
        chk("busy",     int'(busy),     int'(e.busy));
        chk("done",     int'(done),     int'(e.done));
        chk("load_err", int'(load_err), int'(e.err));
      end
    end
  end

  // Load N with enable held high. done must arrive on the N-th edge, and busy must be high for N cycles.
  task automatic latency_run(input int n);
    int bcnt;
    int lat;
    bcnt = 0;
    lat  = -1;
    cycle(0, 1, n, 1);
    @(posedge clk); #2;
    if (busy) bcnt++;
    for (int k = 1; k <= n + 5; k++) begin
      cycle(0, 0, 0, 1);
      @(posedge clk); #2;
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("done_latency", lat, n);
    chk("busy_cycles", bcnt, n);
  endtask

  // Assert reset between edges, check outputs at once, hold it for one edge, then release.
  task automatic async_reset_mid();
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("rst_counter", int'(counter), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_load_err", int'(load_err), 0);
    m_left = 0; m_done = 0; m_err = 0;
    @(negedge clk);
    clear = 0; load = 0; load_value = '0; enable = 1;
    push_expect();
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 0, 1);
  endtask

  initial begin
    int lv;
    int r;
    reset_n = 1'b0; clear = 0; load = 0; load_value = '0; enable = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("init_counter", int'(counter), 0);
    chk("init_busy", int'(busy), 0);
    chk("init_done", int'(done), 0);
    chk("init_load_err", int'(load_err), 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 0, 0);

    // Enable alone does nothing while idle.
    repeat (3) cycle(0, 0, 0, 1);

    // Nominal drain of 5.
    latency_run(5);
    cycle(0, 0, 0, 1);

    // An over-limit load while idle is rejected; the limit value itself drains fully.
    cycle(0, 1, 120, 0);
    cycle(0, 0, 0, 0);
    latency_run(MAX_LOAD);
    cycle(0, 0, 0, 0);

    // Pause, then restart with a new load.
    cycle(0, 1, 8, 1);
    repeat (3) cycle(0, 0, 0, 1);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(0, 1, 3, 1);
    repeat (4) cycle(0, 0, 0, 1);

    // A clear coinciding with a load while running.
    cycle(0, 1, 7, 1);
    cycle(0, 0, 0, 1);
    cycle(1, 1, 7, 1);
    cycle(0, 0, 0, 1);

    // Zero loads, back to back.
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 1);
    cycle(0, 0, 0, 1);

    // Rejected load during a run at 9; the count continues.
    cycle(0, 1, 20, 1);
    repeat (11) cycle(0, 0, 0, 1);
    cycle(0, 1, 200, 1);
    repeat (3) cycle(0, 0, 0, 1);

    // Reset in the middle of a count.
    cycle(0, 1, 50, 1);
    repeat (10) cycle(0, 0, 0, 1);
    async_reset_mid();
    repeat (3) cycle(0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) lv = 0;
      else if (r == 1) lv = $urandom_range(MAX_LOAD + 1, (1 << WIDTH) - 1);
      else if (r == 2) lv = MAX_LOAD;
      else lv = $urandom_range(1, 12);
      cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 5) == 0), lv,
            ($urandom_range(0, 3) != 0));
    end
    cycle(0, 0, 0, 0);

    @(posedge clk); #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
